// File: rtl/micro_sequencer.sv
// Microprogrammed control unit for the ARC datapath: CSAR, MIR and PSR registers,
// two-phase FETCH/EXEC sequencing with memory stalls and next-microaddress selection.
module micro_sequencer #(
  parameter int unsigned DATAWIDTH_MIR               = 41,
  parameter int unsigned DATAWIDTH_CS_ADDRESS        = 11,
  parameter int unsigned DATAWIDTH_BUS_REG_MIR_FIELD = 6,
  parameter int unsigned DATAWIDTH_ALU_SELECTION     = 4,
  parameter int unsigned DATAWIDTH_BUS_REG_IR_OP     = 8,
  parameter logic [DATAWIDTH_CS_ADDRESS-1:0] CS_RESET_ADDRESS = '0
) (
  input  logic                                   uSequencer_CLOCK_50,
  input  logic                                   uSequencer_RESET_InLow,
  input  logic [DATAWIDTH_MIR-1:0]               uSequencer_CS_Data_In,
  output logic [DATAWIDTH_CS_ADDRESS-1:0]        uSequencer_CS_Address_Out,
  input  logic                                   uSequencer_Overflow_InLow,
  input  logic                                   uSequencer_Carry_InLow,
  input  logic                                   uSequencer_Negative_InLow,
  input  logic                                   uSequencer_Zero_InLow,
  input  logic                                   uSequencer_ALU_Flags_Write_PCR,
  input  logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     uSequencer_Reg_IR_OP,
  input  logic                                   uSequencer_Reg_IR_IR13,
  input  logic                                   uSequencer_Memory_Ready_In,
  output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSequencer_MUX_A_MIR,
  output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSequencer_MUX_B_MIR,
  output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSequencer_MUX_C_MIR,
  output logic                                   uSequencer_MUX_A_MIR_Selector,
  output logic                                   uSequencer_MUX_B_MIR_Selector,
  output logic                                   uSequencer_MUX_C_MIR_Selector,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uSequencer_ALU_Selection_Out,
  output logic                                   uSequencer_DataMemory_Read_Out,
  output logic                                   uSequencer_DataMemory_Write_Out,
  output logic                                   uSequencer_DataMemory_Selector_Out,
  output logic [3:0]                             uSequencer_PSR_Out
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t                            state, stateNext;
  logic [DATAWIDTH_CS_ADDRESS-1:0]   csar, csarNext, csarSeq, jumpAddr;
  logic [DATAWIDTH_MIR-1:0]          mir;
  logic [3:0]                        psr;
  logic [2:0]                        cond;
  logic                              mirRd, mirWr, stall;

  assign mirRd    = mir[19];
  assign mirWr    = mir[18];
  assign cond     = mir[13:11];
  assign jumpAddr = mir[10:0];
  assign csarSeq  = csar + 1'b1;
  assign stall    = (state == EXEC) && (mirRd || mirWr) && !uSequencer_Memory_Ready_In;

  // Branch conditions test the PSR latched before this microinstruction completes.
  always_comb begin
    csarNext = csarSeq;
    unique case (cond)
      3'b000: csarNext = csarSeq;
      3'b001: csarNext = psr[3] ? jumpAddr : csarSeq;
      3'b010: csarNext = psr[2] ? jumpAddr : csarSeq;
      3'b011: csarNext = psr[1] ? jumpAddr : csarSeq;
      3'b100: csarNext = psr[0] ? jumpAddr : csarSeq;
      3'b101: csarNext = uSequencer_Reg_IR_IR13 ? jumpAddr : csarSeq;
      3'b110: csarNext = jumpAddr;
      3'b111: csarNext = {1'b1, uSequencer_Reg_IR_OP, 2'b00};
      default: csarNext = csarSeq;
    endcase
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      FETCH: stateNext = EXEC;
      EXEC:  stateNext = stall ? EXEC : FETCH;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge uSequencer_CLOCK_50 or negedge uSequencer_RESET_InLow) begin
    if (!uSequencer_RESET_InLow) begin
      state <= FETCH;
      csar  <= CS_RESET_ADDRESS;
      mir   <= '0;
      psr   <= '0;
    end else begin
      state <= stateNext;
      if (state == FETCH) begin
        mir <= uSequencer_CS_Data_In;
      end else if (!stall) begin
        csar <= csarNext;
        if (uSequencer_ALU_Flags_Write_PCR)
          psr <= {~uSequencer_Negative_InLow, ~uSequencer_Zero_InLow,
                  ~uSequencer_Overflow_InLow, ~uSequencer_Carry_InLow};
      end
    end
  end

  // C field only writes the register file on a completing EXEC cycle.
  always_comb begin
    uSequencer_CS_Address_Out          = csar;
    uSequencer_MUX_A_MIR               = mir[40:35];
    uSequencer_MUX_A_MIR_Selector      = mir[34];
    uSequencer_MUX_B_MIR               = mir[33:28];
    uSequencer_MUX_B_MIR_Selector      = mir[27];
    uSequencer_MUX_C_MIR               = '0;
    uSequencer_MUX_C_MIR_Selector      = mir[20];
    uSequencer_ALU_Selection_Out       = mir[17:14];
    uSequencer_DataMemory_Read_Out     = 1'b0;
    uSequencer_DataMemory_Write_Out    = 1'b0;
    uSequencer_PSR_Out                 = psr;
    if (state == EXEC) begin
      uSequencer_DataMemory_Read_Out  = mirRd;
      uSequencer_DataMemory_Write_Out = mirWr;
      if (!stall)
        uSequencer_MUX_C_MIR = mir[26:21];
    end
    uSequencer_DataMemory_Selector_Out = uSequencer_DataMemory_Read_Out;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed vector table, hand-written
// stall/reset sequences and a randomized run against a behavioural model.
module tb_micro_sequencer;

  logic        clk, rstN;
  logic [40:0] csData;
  logic [10:0] csAddr;
  logic        ovfL, carL, negL, zerL, flagsWr;
  logic [7:0]  irOp;
  logic        ir13, memReady;
  logic [5:0]  aOut, bOut, cOut;
  logic        aSel, bSel, cSel;
  logic [3:0]  aluOut;
  logic        rdOut, wrOut, selOut;
  logic [3:0]  psrOut;

  logic [40:0] rom [2048];
  assign csData = rom[csAddr];

  micro_sequencer dut (
    .uSequencer_CLOCK_50               (clk),
    .uSequencer_RESET_InLow            (rstN),
    .uSequencer_CS_Data_In             (csData),
    .uSequencer_CS_Address_Out         (csAddr),
    .uSequencer_Overflow_InLow         (ovfL),
    .uSequencer_Carry_InLow            (carL),
    .uSequencer_Negative_InLow         (negL),
    .uSequencer_Zero_InLow             (zerL),
    .uSequencer_ALU_Flags_Write_PCR    (flagsWr),
    .uSequencer_Reg_IR_OP              (irOp),
    .uSequencer_Reg_IR_IR13            (ir13),
    .uSequencer_Memory_Ready_In        (memReady),
    .uSequencer_MUX_A_MIR              (aOut),
    .uSequencer_MUX_B_MIR              (bOut),
    .uSequencer_MUX_C_MIR              (cOut),
    .uSequencer_MUX_A_MIR_Selector     (aSel),
    .uSequencer_MUX_B_MIR_Selector     (bSel),
    .uSequencer_MUX_C_MIR_Selector     (cSel),
    .uSequencer_ALU_Selection_Out      (aluOut),
    .uSequencer_DataMemory_Read_Out    (rdOut),
    .uSequencer_DataMemory_Write_Out   (wrOut),
    .uSequencer_DataMemory_Selector_Out(selOut),
    .uSequencer_PSR_Out                (psrOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {A,AMUX,B,BMUX,C,CMUX,RD,WR,ALU,COND,JADDR}
  function automatic logic [40:0] mw(input logic [5:0] c, input logic rd, input logic wr,
                                     input logic [2:0] cnd, input logic [10:0] j,
                                     input logic [5:0] a, input logic [3:0] alu);
    return {a, 1'b1, 6'h2A, 1'b0, c, 1'b1, rd, wr, alu, cnd, j};
  endfunction

  typedef struct {
    logic [40:0] word;
    logic [3:0]  flagsLow;   // {n,z,v,c} active-low
    logic        fw;
    logic [7:0]  op;
    logic        ir13;
    logic [10:0] start;
    logic [10:0] expNext;
    logic [3:0]  expPsr;
  } vec_t;

  vec_t vecs [18];

  task automatic setVec(input int unsigned i, input logic [40:0] w, input logic [3:0] fl,
                        input logic fw, input logic [7:0] op, input logic i13,
                        input logic [10:0] st, input logic [10:0] nx, input logic [3:0] ps);
    vecs[i].word = w;   vecs[i].flagsLow = fl; vecs[i].fw = fw; vecs[i].op = op;
    vecs[i].ir13 = i13; vecs[i].start = st;    vecs[i].expNext = nx; vecs[i].expPsr = ps;
  endtask

  task automatic applyFlags(input logic [3:0] fl);
    negL = fl[3]; zerL = fl[2]; ovfL = fl[1]; carL = fl[0];
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " addr"}, csAddr, 0);
    check({tag, " ctl"}, {aOut, bOut, cOut, aSel, bSel, cSel, aluOut, rdOut, wrOut, selOut}, 0);
    check({tag, " psr"}, psrOut, 0);
  endtask

  // Behavioural model state
  logic [10:0] cur;
  logic        mN, mZ, mV, mC;
  logic [40:0] lastWord, w;
  logic [3:0]  fl;
  logic        fwR, take;
  int unsigned stalls;
  logic [10:0] nxt;

  initial begin
    for (int unsigned i = 0; i < 2048; i++) rom[i] = '0;
    rstN = 1'b0; memReady = 1'b1; flagsWr = 1'b0; irOp = '0; ir13 = 1'b0;
    applyFlags(4'b1111);

    // cond: 0 seq, 1 n, 2 z, 3 v, 4 c, 5 ir13, 6 jump, 7 decode
    setVec(0,  mw(6'd5, 0, 0, 3'd0, 11'd0,    6'd1, 4'h1), 4'hF, 0, 8'h00, 0, 11'd0,    11'd1,    4'b0000);
    setVec(1,  mw(6'd7, 0, 0, 3'd0, 11'd0,    6'd2, 4'h2), 4'hF, 0, 8'h00, 0, 11'd1,    11'd2,    4'b0000);
    setVec(2,  mw(6'd1, 0, 0, 3'd6, 11'd2047, 6'd3, 4'h3), 4'hF, 0, 8'h00, 0, 11'd2,    11'd2047, 4'b0000);
    setVec(3,  mw(6'd2, 0, 0, 3'd0, 11'd0,    6'd4, 4'h4), 4'hF, 0, 8'h00, 0, 11'd2047, 11'd0,    4'b0000);
    setVec(4,  mw(6'd3, 0, 0, 3'd6, 11'd5,    6'd5, 4'h5), 4'hF, 0, 8'h00, 0, 11'd0,    11'd5,    4'b0000);
    setVec(5,  mw(6'd4, 0, 0, 3'd2, 11'd100,  6'd6, 4'h6), 4'hB, 1, 8'h00, 0, 11'd5,    11'd6,    4'b0100);
    setVec(6,  mw(6'd6, 0, 0, 3'd2, 11'd100,  6'd7, 4'h7), 4'hF, 0, 8'h00, 0, 11'd6,    11'd100,  4'b0100);
    setVec(7,  mw(6'd8, 0, 0, 3'd6, 11'd5,    6'd8, 4'h8), 4'hF, 1, 8'h00, 0, 11'd100,  11'd5,    4'b0000);
    setVec(8,  mw(6'd9, 0, 0, 3'd2, 11'd100,  6'd9, 4'h9), 4'hF, 1, 8'h00, 0, 11'd5,    11'd6,    4'b0000);
    setVec(9,  mw(6'd10,0, 0, 3'd2, 11'd100,  6'd10,4'hA), 4'hF, 0, 8'h00, 0, 11'd6,    11'd7,    4'b0000);
    setVec(10, mw(6'd11,0, 0, 3'd7, 11'd0,    6'd11,4'hB), 4'hF, 0, 8'h80, 0, 11'd7,    11'h600,  4'b0000);
    setVec(11, mw(6'd12,0, 0, 3'd7, 11'd0,    6'd12,4'hC), 4'hF, 0, 8'hFF, 0, 11'h600,  11'h7FC,  4'b0000);
    setVec(12, mw(6'd13,0, 0, 3'd1, 11'd300,  6'd13,4'hD), 4'h6, 1, 8'h00, 0, 11'h7FC,  11'h7FD,  4'b1001);
    setVec(13, mw(6'd14,0, 0, 3'd1, 11'd300,  6'd14,4'hE), 4'hF, 0, 8'h00, 0, 11'h7FD,  11'd300,  4'b1001);
    setVec(14, mw(6'd15,0, 0, 3'd4, 11'd400,  6'd15,4'hF), 4'hF, 0, 8'h00, 0, 11'd300,  11'd400,  4'b1001);
    setVec(15, mw(6'd16,0, 0, 3'd3, 11'd500,  6'd16,4'h0), 4'hF, 0, 8'h00, 0, 11'd400,  11'd401,  4'b1001);
    setVec(16, mw(6'd17,0, 0, 3'd5, 11'd10,   6'd17,4'h1), 4'hF, 0, 8'h00, 1, 11'd401,  11'd10,   4'b1001);
    setVec(17, mw(6'd18,0, 0, 3'd5, 11'd20,   6'd18,4'h2), 4'hF, 0, 8'h00, 0, 11'd10,   11'd11,   4'b1001);

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    #1 checkAllZero("post-reset");

    // Directed table
    for (int unsigned i = 0; i < 18; i++) begin
      rom[vecs[i].start] = vecs[i].word;
      applyFlags(vecs[i].flagsLow);
      flagsWr = vecs[i].fw; irOp = vecs[i].op; ir13 = vecs[i].ir13;
      #1;
      check($sformatf("vec%0d fetch addr", i), csAddr, vecs[i].start);
      check($sformatf("vec%0d fetch C", i), cOut, 0);
      check($sformatf("vec%0d fetch rd", i), rdOut, 0);
      @(negedge clk);
      check($sformatf("vec%0d exec C", i), cOut, vecs[i].word[26:21]);
      check($sformatf("vec%0d exec A/ALU", i), {aOut, aluOut}, {vecs[i].word[40:35], vecs[i].word[17:14]});
      check($sformatf("vec%0d exec addr", i), csAddr, vecs[i].start);
      @(negedge clk);
      check($sformatf("vec%0d next addr", i), csAddr, vecs[i].expNext);
      check($sformatf("vec%0d psr", i), psrOut, vecs[i].expPsr);
    end
    flagsWr = 1'b0;

    // Memory read stall at address 11
    rom[11] = mw(6'd3, 1, 0, 3'd0, 11'd0, 6'd20, 4'h5);
    memReady = 1'b0;
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      check($sformatf("stall%0d rd/sel", k), {rdOut, selOut, wrOut}, 3'b110);
      check($sformatf("stall%0d C", k), cOut, 0);
      check($sformatf("stall%0d addr", k), csAddr, 11);
      @(negedge clk);
    end
    memReady = 1'b1;
    #1 check("stall release C", cOut, 3);
    check("stall release addr", csAddr, 11);
    @(negedge clk);
    check("after stall addr", csAddr, 12);
    check("after stall rd", {rdOut, selOut}, 0);

    // Reset during a stalled write
    rom[12] = mw(6'd4, 0, 1, 3'd0, 11'd0, 6'd21, 4'h6);
    memReady = 1'b0;
    @(negedge clk);
    check("wr stall c1", wrOut, 1);
    @(negedge clk);
    check("wr stall c2", wrOut, 1);
    #2 rstN = 1'b0;
    #1 checkAllZero("async reset");
    memReady = 1'b1;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    rom[0] = mw(6'd9, 0, 0, 3'd0, 11'd0, 6'd22, 4'h7);
    #1 check("restart addr", csAddr, 0);
    @(negedge clk);
    check("restart exec C", cOut, 9);
    @(negedge clk);
    check("restart next", csAddr, 1);

    // Randomized run against the model
    cur = 11'd1; lastWord = rom[0];
    mN = 0; mZ = 0; mV = 0; mC = 0;
    for (int unsigned t = 0; t < 300; t++) begin
      w = {$urandom, $urandom};
      fl = 4'($urandom); fwR = 1'($urandom);
      rom[cur] = w;
      applyFlags(fl); flagsWr = fwR; irOp = 8'($urandom); ir13 = 1'($urandom);
      stalls = (w[19] | w[18]) ? $urandom_range(0, 3) : 0;
      memReady = (w[19] | w[18]) ? (stalls == 0) : 1'($urandom);
      #1;
      check("rnd fetch addr", csAddr, cur);
      check("rnd fetch psr", psrOut, {mN, mZ, mV, mC});
      check("rnd fetch ctl", {cOut, rdOut, wrOut, selOut}, 0);
      check("rnd fetch fields", {aOut, aSel, bOut, bSel, cSel, aluOut},
            {lastWord[40:27], lastWord[20], lastWord[17:14]});
      @(negedge clk);
      for (int unsigned k = 0; k < stalls; k++) begin
        check("rnd stall", {cOut, rdOut, wrOut, selOut, csAddr}, {6'd0, w[19], w[18], w[19], cur});
        @(negedge clk);
      end
      memReady = 1'b1;
      #1 check("rnd exec fields", {aOut, aSel, bOut, bSel, cOut, cSel, rdOut, wrOut, aluOut, selOut},
               {w[40:14], w[19]});
      case (w[13:11])
        3'd0: take = 1'b0;
        3'd1: take = mN;
        3'd2: take = mZ;
        3'd3: take = mV;
        3'd4: take = mC;
        3'd5: take = ir13;
        default: take = 1'b1;
      endcase
      if (w[13:11] == 3'd7) nxt = 11'(1024 + 4 * int'(irOp));
      else if (take)        nxt = w[10:0];
      else                  nxt = 11'((int'(cur) + 1) % 2048);
      if (fwR) begin
        mN = ~fl[3]; mZ = ~fl[2]; mV = ~fl[1]; mC = ~fl[0];
      end
      cur = nxt; lastWord = w;
      @(negedge clk);
    end
    #1 check("final addr", csAddr, cur);
    check("final psr", psrOut, {mN, mZ, mV, mC});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Microprogrammed control unit that sits directly upstream of the ARC datapath. It holds the control-store address register (CSAR), the microinstruction register (MIR) and the processor status flags (PSR). It computes the next microaddress from the COND field, the latched flags, IR[13] and the IR opcode. It drives every datapath control field: A/B/C register fields and selectors, ALU selection, and the memory read/write/selector signals. The control store ROM is external and combinational; this block supplies its address and latches its data.

Parameters:
DATAWIDTH_MIR, 41, microword width
DATAWIDTH_CS_ADDRESS, 11, control-store address width
DATAWIDTH_BUS_REG_MIR_FIELD, 6, width of the A/B/C register fields
DATAWIDTH_ALU_SELECTION, 4, width of the ALU opcode field
DATAWIDTH_BUS_REG_IR_OP, 8, width of the IR opcode used for decode
CS_RESET_ADDRESS, 11'd0, CSAR value after reset
Only the defaults are supported; the field layout below is fixed to them.

Ports:
uSequencer_CLOCK_50  in  1  system clock, rising edge
uSequencer_RESET_InLow  in  1  asynchronous, active-low reset
uSequencer_CS_Data_In  in  41  microword returned by the ROM for uSequencer_CS_Address_Out
uSequencer_CS_Address_Out  out  11  current CSAR value
uSequencer_Overflow_InLow / _Carry_InLow / _Negative_InLow / _Zero_InLow  in  1 each  ALU flags, active-low
uSequencer_ALU_Flags_Write_PCR  in  1  ALU request to update the PSR
uSequencer_Reg_IR_OP  in  8  IR opcode bits
uSequencer_Reg_IR_IR13  in  1  IR bit 13
uSequencer_Memory_Ready_In  in  1  data-memory access complete
uSequencer_MUX_A_MIR / _MUX_B_MIR / _MUX_C_MIR  out  6 each  MIR A/B/C fields
uSequencer_MUX_A_MIR_Selector / _B_ / _C_  out  1 each  AMUX/BMUX/CMUX bits
uSequencer_ALU_Selection_Out  out  4  MIR ALU field
uSequencer_DataMemory_Read_Out  out  1  memory read strobe
uSequencer_DataMemory_Write_Out  out  1  memory write strobe
uSequencer_DataMemory_Selector_Out  out  1  selects memory data onto the C bus (equals the read strobe)
uSequencer_PSR_Out  out  4  {n,z,v,c}, active-high

Behaviour:
- Reset (asynchronous, active-low): CSAR=CS_RESET_ADDRESS, MIR=0, PSR=0, state=FETCH. All outputs are 0 except CS_Address_Out=CS_RESET_ADDRESS. Assertion mid-operation aborts any stall immediately.
- MIR layout [40:0]: A[40:35] AMUX[34] B[33:28] BMUX[27] C[26:21] CMUX[20] RD[19] WR[18] ALU[17:14] COND[13:11] JADDR[10:0].
- FSM states: FETCH, EXEC. Each microinstruction takes 2 cycles, plus stall cycles.
- FETCH: CS_Address_Out=CSAR. At the clock edge: MIR<=CS_Data_In, state goes to EXEC.
- In FETCH: C output=0 (no register write); RD, WR and the memory selector are 0; the other fields reflect the MIR.
- EXEC: all fields are driven from the MIR.
- Stall: when (RD|WR)=1 and Memory_Ready_In=0.
  - RD/WR stay asserted.
  - C output is forced to 0.
  - CSAR, MIR and PSR hold; state remains EXEC.
- EXEC completion edge (no stall):
  - If ALU_Flags_Write_PCR=1, PSR<={~Negative,~Zero,~Overflow,~Carry} (InLow inputs inverted).
  - CSAR<=next address; state goes to FETCH.
- Next-address selection by COND, evaluated on the PSR value held during EXEC (a flag set in the same microinstruction is not visible to its own branch):
  - 000: CSAR+1, modulo 2^11 (2047 wraps to 0).
  - 001/010/011/100: JADDR if n/z/v/c respectively, else CSAR+1.
  - 101: JADDR if IR13, else CSAR+1.
  - 110: JADDR unconditionally.
  - 111 (decode): {1'b1, Reg_IR_OP[7:0], 2'b00}.
- Memory_Ready_In is ignored when RD=WR=0.
- RD=WR=1 in the same microword is legal; both strobes are driven and the memory defines the result.

Test Plan:
1. Assert reset for 3 cycles, then release. CS_Address_Out=0, all control outputs 0, PSR=0; the first FETCH loads ROM[0].
2. ROM[0]: COND=000, C=6'd5. Required: C output=0 in FETCH and 5 in EXEC; address sequence 0, 1, 2 at 2-cycle intervals. Preload CSAR to 2047 via a JADDR=2047 jump; with COND=000 the next address is 0.
3. Flags and branch on z:
   - ROM[5] asserts Flags_Write with Zero_InLow=0 and COND=010, JADDR=100: next address is 6 (old z=0), then PSR_Out=4'b0100.
   - ROM[6]: COND=010, JADDR=100: next address is 100.
   - Repeat with Zero_InLow=1: next address is 7.
4. Decode: Reg_IR_OP=8'h80, COND=111: next address is 11'h600. Repeat with OP=8'hFF: next address is 11'h7FC.
5. Memory stall: microword RD=1, C=6'd3, Memory_Ready_In=0 for 3 cycles.
   - During the stall: Read_Out=1, Selector_Out=1, C output=0, CS_Address_Out constant.
   - Raise ready: C output=3 for that cycle, CSAR advances on the next edge.
6. Assert reset during cycle 2 of a stalled WR: all outputs go to 0 with no clock edge; after release the sequencer restarts at address 0.
